lfsr_generator: RTL and testbench

//  Source stage feeding lfsr_checker: emits an 8-bit LFSR sequence as valid-strobed words.

---
 rtl/lfsr_pkg.sv | 38 +++
 rtl/lfsr_generator.sv | 168 ++++++++++++++++
 tb/tb_lfsr_generator.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/lfsr_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : lfsr_pkg
//  Description : Definitions shared by lfsr_generator and lfsr_checker:
//                LFSR width, default seed, the de Bruijn next-state function
//                for x^8+x^4+x^3+x^2+1 (period 256, all-zero state included)
//                and the generator FSM state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package lfsr_pkg;

    localparam int                  LFSR_W            = 8;
    localparam logic [LFSR_W-1:0]   LFSR_DEFAULT_SEED = 8'h01;

    // Generator FSM encoding
    localparam logic [1:0] C_ST_IDLE = 2'd0;
    localparam logic [1:0] C_ST_RUN  = 2'd1;
    localparam logic [1:0] C_ST_GAP  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = C_ST_IDLE,
        ST_RUN  = C_ST_RUN,
        ST_GAP  = C_ST_GAP
    } fsm_state_t;

    // Galois step with the de Bruijn correction: the feedback bit is
    // inverted when s[6:0] is zero, which splices 8'h00 into the cycle
    // between 8'h80 and 8'h1D and makes the period a full 256.
    function automatic logic [LFSR_W-1:0] lfsr8_next(input logic [LFSR_W-1:0] s);
        logic f;
        f = s[7] ^ (s[6:0] == 7'd0);
        return {s[6], s[5], s[4], s[3] ^ f, s[2] ^ f, s[1] ^ f, s[0], f};
    endfunction

endpackage

`default_nettype wire

// File: rtl/lfsr_generator.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : lfsr_generator
//  Description : Source stage for lfsr_checker. Emits the 8-bit de Bruijn
//                LFSR sequence as valid-strobed words, with programmable idle
//                gaps, runtime seed reload and one-shot error injection.
//  Ports       : clk           - clock, rising edge
//                i_rst_n       - asynchronous active-low reset
//                i_enable      - 1 = generate words, 0 = hold state
//                i_gap         - idle cycles after each word (sampled on emit)
//                i_seed_load   - pulse: load i_seed into seed reg and state
//                i_seed        - seed value for i_seed_load
//                i_inject_err  - pulse: corrupt the next emitted word
//                i_err_mask    - XOR mask for the corrupted word
//                o_lfsr        - emitted word (registered)
//                o_valid       - o_lfsr valid this cycle
//                o_seed_reg    - current seed register
//                o_period_done - pulse with every 256th word since load/reset
//                o_word_count  - words emitted since load/reset (wraps)
//  Revision    : 1.0 - initial release
// ============================================================================
module lfsr_generator
    import lfsr_pkg::*;
#(
    parameter logic [LFSR_W-1:0] DEFAULT_SEED = LFSR_DEFAULT_SEED,
    parameter int                GAP_W        = 4,
    parameter int                CNT_W        = 16   // must be >= 8
) (
    input  logic                clk,
    input  logic                i_rst_n,
    input  logic                i_enable,
    input  logic [GAP_W-1:0]    i_gap,
    input  logic                i_seed_load,
    input  logic [LFSR_W-1:0]   i_seed,
    input  logic                i_inject_err,
    input  logic [LFSR_W-1:0]   i_err_mask,
    output logic [LFSR_W-1:0]   o_lfsr,
    output logic                o_valid,
    output logic [LFSR_W-1:0]   o_seed_reg,
    output logic                o_period_done,
    output logic [CNT_W-1:0]    o_word_count
);

    fsm_state_t             r_fsm;
    fsm_state_t             w_fsm_next;
    logic [GAP_W-1:0]       r_gap_cnt;
    logic [GAP_W-1:0]       w_gap_cnt_next;
    logic                   w_emit;
    logic [LFSR_W-1:0]      w_mask;

    logic [LFSR_W-1:0]      r_state;
    logic [LFSR_W-1:0]      r_seed;
    logic [LFSR_W-1:0]      r_lfsr;
    logic                   r_valid;
    logic                   r_period_done;
    logic [CNT_W-1:0]       r_word_count;
    logic                   r_err_pending;
    logic [LFSR_W-1:0]      r_err_mask;

    // ------------------------------------------------------------------
    // FSM next-state. Seed load beats everything; dropping i_enable
    // parks in IDLE with the gap counter cleared but the LFSR state kept,
    // so re-enabling resumes the sequence without skipping a word.
    // ------------------------------------------------------------------
    always_comb begin
        w_fsm_next     = r_fsm;
        w_gap_cnt_next = r_gap_cnt;
        w_emit         = 1'b0;
        if (i_seed_load) begin
            w_fsm_next     = i_enable ? ST_RUN : ST_IDLE;
            w_gap_cnt_next = '0;
        end else if (!i_enable) begin
            w_fsm_next     = ST_IDLE;
            w_gap_cnt_next = '0;
        end else begin
            case (r_fsm)
                ST_IDLE: w_fsm_next = ST_RUN;
                ST_RUN: begin
                    w_emit = 1'b1;
                    if (i_gap != '0) begin
                        // Counts i_gap idle cycles: GAP exits on the edge
                        // where the counter is already zero.
                        w_gap_cnt_next = i_gap - GAP_W'(1);
                        w_fsm_next     = ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (r_gap_cnt == '0) begin
                        w_fsm_next = ST_RUN;
                    end else begin
                        w_gap_cnt_next = r_gap_cnt - GAP_W'(1);
                    end
                end
                default: begin
                    w_fsm_next     = ST_IDLE;
                    w_gap_cnt_next = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_fsm     <= ST_IDLE;
            r_gap_cnt <= '0;
        end else begin
            r_fsm     <= w_fsm_next;
            r_gap_cnt <= w_gap_cnt_next;
        end
    end

    // A pulse coincident with an emitted word corrupts that word directly;
    // otherwise the latched mask is used until it has been consumed.
    always_comb begin
        if (i_inject_err) begin
            w_mask = i_err_mask;
        end else if (r_err_pending) begin
            w_mask = r_err_mask;
        end else begin
            w_mask = '0;
        end
    end

    // ------------------------------------------------------------------
    // Datapath and counters. The mask only touches the output word; the
    // LFSR state always advances uncorrupted.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= DEFAULT_SEED;
            r_seed        <= DEFAULT_SEED;
            r_lfsr        <= '0;
            r_valid       <= 1'b0;
            r_period_done <= 1'b0;
            r_word_count  <= '0;
            r_err_pending <= 1'b0;
            r_err_mask    <= '0;
        end else begin
            r_valid       <= w_emit;
            r_period_done <= w_emit && (r_word_count[7:0] == 8'hFF);
            if (i_seed_load) begin
                r_state       <= i_seed;
                r_seed        <= i_seed;
                r_word_count  <= '0;
                r_err_pending <= 1'b0;
            end else if (w_emit) begin
                r_lfsr        <= r_state ^ w_mask;
                r_state       <= lfsr8_next(r_state);
                r_word_count  <= r_word_count + CNT_W'(1);
                r_err_pending <= 1'b0;
            end else if (i_inject_err) begin
                // A later pulse before consumption simply replaces the mask.
                r_err_pending <= 1'b1;
                r_err_mask    <= i_err_mask;
            end
        end
    end

    assign o_lfsr        = r_lfsr;
    assign o_valid       = r_valid;
    assign o_seed_reg    = r_seed;
    assign o_period_done = r_period_done;
    assign o_word_count  = r_word_count;

endmodule

`default_nettype wire

// File: tb/tb_lfsr_generator.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_lfsr_generator
//  Description : Self-checking bench for lfsr_generator. A cycle-level
//                reference model (countdown to next word, arithmetic LFSR
//                step) is compared against the DUT after every clock edge,
//                alongside directed checks of known sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lfsr_generator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [3:0]  gap;
    logic        seed_load;
    logic [7:0]  seed;
    logic        inj;
    logic [7:0]  emask;
    logic [7:0]  o_lfsr;
    logic        o_valid;
    logic [7:0]  o_seed_reg;
    logic        o_pd;
    logic [15:0] o_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    int   m_state, m_seed, m_count, m_wait, m_pmask;
    bit   m_pending;
    int   m_lfsr;
    bit   m_valid, m_pd;

    always #5 clk = ~clk;

    lfsr_generator #(
        .DEFAULT_SEED (8'h01),
        .GAP_W        (4),
        .CNT_W        (16)
    ) dut (
        .clk           (clk),
        .i_rst_n       (rst_n),
        .i_enable      (en),
        .i_gap         (gap),
        .i_seed_load   (seed_load),
        .i_seed        (seed),
        .i_inject_err  (inj),
        .i_err_mask    (emask),
        .o_lfsr        (o_lfsr),
        .o_valid       (o_valid),
        .o_seed_reg    (o_seed_reg),
        .o_period_done (o_pd),
        .o_word_count  (o_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Shift left, fold in the polynomial taps 0x1D when the feedback bit
    // (msb, flipped when the low seven bits are all zero) is set.
    function automatic int ref_next(input int s);
        bit f;
        f = (s >= 128) != ((s % 128) == 0);
        return ((s * 2) % 256) ^ (f ? 32'h1D : 32'h0);
    endfunction

    task automatic model_reset();
        m_state = 1; m_seed = 1; m_count = 0; m_wait = 1;
        m_pending = 0; m_pmask = 0; m_lfsr = 0; m_valid = 0; m_pd = 0;
    endtask

    // m_wait = enabled non-emitting edges still to pass before the next word.
    task automatic model_edge();
        int mask;
        m_valid = 0;
        m_pd    = 0;
        if (!rst_n) begin
            model_reset();
        end else if (seed_load) begin
            m_state = seed; m_seed = seed; m_count = 0; m_pending = 0;
            m_wait  = en ? 0 : 1;
        end else if (!en) begin
            m_wait = 1;
            if (inj) begin m_pending = 1; m_pmask = emask; end
        end else if (m_wait == 0) begin
            mask      = inj ? int'(emask) : (m_pending ? m_pmask : 0);
            m_lfsr    = m_state ^ mask;
            m_valid   = 1;
            m_pd      = (m_count % 256) == 255;
            m_count   = m_count + 1;
            m_state   = ref_next(m_state);
            m_pending = 0;
            m_wait    = gap;
        end else begin
            m_wait = m_wait - 1;
            if (inj) begin m_pending = 1; m_pmask = emask; end
        end
    endtask

    task automatic check_outputs();
        chk("valid",    o_valid,    m_valid);
        chk("lfsr",     o_lfsr,     m_lfsr);
        chk("seed_reg", o_seed_reg, m_seed);
        chk("count",    o_cnt,      m_count % 65536);
        chk("pdone",    o_pd,       m_pd);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    // Advance until a valid word; n = edges taken.
    task automatic next_word(output logic [7:0] w, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!o_valid && n < 40);
        if (!o_valid) chk("word_timeout", o_valid, 1);
        w = o_lfsr;
    endtask

    task automatic load(input logic [7:0] s);
        seed_load = 1; seed = s;
        step();
        seed_load = 0;
    endtask

    logic [7:0] exp1 [10];
    logic [7:0] w;
    int         n;

    initial begin
        exp1 = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h00, 8'h1D};
        rst_n = 0; en = 0; gap = 0; seed_load = 0; seed = 0; inj = 0; emask = 0;
        model_reset();
        #12;
        check_outputs();
        chk("rst_seed_reg", o_seed_reg, 8'h01);
        chk("rst_valid",    o_valid,    1'b0);
        rst_n = 1;
        step();

        // 1: gap 0, consecutive words from seed 01
        en = 1;
        for (int i = 0; i < 10; i++) begin
            next_word(w, n);
            chk("t1_word", w, exp1[i]);
            chk("t1_spacing", n, (i == 0) ? 2 : 1);
        end

        // 2: gap 2, same sequence one word in three cycles
        gap = 2;
        load(8'h01);
        chk("t2_load_valid", o_valid, 1'b0);
        for (int i = 0; i < 10; i++) begin
            next_word(w, n);
            chk("t2_word", w, exp1[i]);
            chk("t2_spacing", n, (i == 0) ? 1 : 3);
        end

        // 3: full period
        gap = 0;
        load(8'h01);
        for (int i = 0; i < 256; i++) begin
            next_word(w, n);
            if (i == 255) begin
                chk("t3_pdone", o_pd, 1'b1);
                chk("t3_count", o_cnt, 16'd256);
            end
        end
        next_word(w, n);
        chk("t3_word257", w, 8'h01);
        chk("t3_pdone_off", o_pd, 1'b0);

        // 4: inject 0xFF during a gap cycle
        gap = 1;
        load(8'h01);
        next_word(w, n);
        next_word(w, n);
        chk("t4_pre", w, 8'h02);
        inj = 1; emask = 8'hFF;
        step();
        inj = 0;
        chk("t4_gap_valid", o_valid, 1'b0);
        next_word(w, n);
        chk("t4_corrupt", w, 8'hFB);
        next_word(w, n);
        chk("t4_clean", w, 8'h08);

        // 5: seed 00 mid-run
        gap = 0;
        load(8'h01);
        for (int i = 0; i < 5; i++) next_word(w, n);
        load(8'h00);
        chk("t5_valid_gap", o_valid, 1'b0);
        chk("t5_seed_reg", o_seed_reg, 8'h00);
        next_word(w, n);
        chk("t5_w0", w, 8'h00);
        chk("t5_w0_lat", n, 1);
        chk("t5_cnt1", o_cnt, 16'd1);
        next_word(w, n);
        chk("t5_w1", w, 8'h1D);

        // 6: async reset mid-gap, then enable drop/resume
        gap = 5;
        next_word(w, n);
        step();
        step();
        #2;
        rst_n = 0;
        #1;
        model_reset();
        check_outputs();
        chk("t6_rst_lfsr",  o_lfsr,     8'h00);
        chk("t6_rst_seed",  o_seed_reg, 8'h01);
        chk("t6_rst_count", o_cnt,      16'd0);
        step();
        rst_n = 1;
        gap = 0;
        next_word(w, n);
        chk("t6_after_rst", w, 8'h01);
        next_word(w, n);
        en = 0;
        step();
        chk("t6_dis_valid", o_valid, 1'b0);
        step();
        en = 1;
        next_word(w, n);
        chk("t6_resume", w, 8'h04);
        chk("t6_resume_lat", n, 2);

        // 7: randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            en        = ($urandom % 16) != 0;
            gap       = (($urandom % 3) == 0) ? 4'($urandom % 16) : 4'($urandom % 2);
            inj       = ($urandom % 10) == 0;
            emask     = 8'($urandom);
            seed_load = ($urandom % 60) == 0;
            seed      = 8'($urandom);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
